torque_bar_animator: RTL and testbench

//  Clocked, parametrised successor to the combinational torque bar display. It drives two
//  LED bar graphs: left = LEDR[17:9], right = LEDR[8:0]. The bars show commanded direction
//  and torque magnitude. Bars ramp one LED per step tick toward their target level.
//  On a direction reversal, the old side drains to zero before the new side lights.

---
 rtl/torque_pkg.sv | 13 +
 rtl/torque_tick_gen.sv | 25 ++
 rtl/torque_bar_animator.sv | 138 +++++++++++++
 tb/tb_torque_bar_animator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/torque_pkg.sv
// Shared types and the torque-to-bar-level mapping for the torque bar display.
package torque_pkg;

  typedef enum logic [1:0] {STOP = 2'b00, LEFT = 2'b01, RIGHT = 2'b10, FWD = 2'b11} instr_e;

  typedef enum logic [1:0] {IDLE, TRACK, DRAIN} disp_state_e;

  // Floor of torque*n_led/tmax; full torque lights the whole bar.
  function automatic int level_of(input int torque, input int n_led, input int tmax);
    return (torque * n_led) / tmax;
  endfunction

endpackage

// File: rtl/torque_tick_gen.sv
// Ramp-step prescaler: one-cycle tick every DIV enabled clocks, held at 0 while disabled.
module torque_tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

// File: rtl/torque_bar_animator.sv
// Two LED bar graphs ramping one LED per step tick toward the commanded torque level;
// inputs land one clock late, reversals drain the old side first. TORQUE_HAZARD_EN adds the STOP blink.
module torque_bar_animator
  import torque_pkg::*;
#(
  parameter int N_LED     = 9,
  parameter int TORQUE_W  = 2,
  parameter int STEP_DIV  = 2_500_000,
  parameter int BLINK_DIV = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [1:0]          instruction,
  input  logic [TORQUE_W-1:0] torque,
  output logic [N_LED-1:0]    left_LED,
  output logic [N_LED-1:0]    right_LED,
  output logic                settled
);
  localparam int TMAX = 2**TORQUE_W - 1;
  localparam int LW   = $clog2(N_LED + 1);

  typedef logic [LW-1:0] lvl_t;

  instr_e              instr_q, instr_prev;
  logic [TORQUE_W-1:0] torque_q;
  disp_state_e         state;
  lvl_t                lvl_l, lvl_r, tgt, tgt_l, tgt_r, drain_lvl;
  logic                tick, drain_left, rev_to_right, rev_to_left, enter_drain, drain_sel;

  function automatic lvl_t step_to(input lvl_t cur, input lvl_t dst);
    if (cur < dst) return cur + lvl_t'(1);
    if (cur > dst) return cur - lvl_t'(1);
    return cur;
  endfunction

  torque_tick_gen #(.DIV(STEP_DIV)) u_step (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (enable),
    .tick (tick)
  );

  assign tgt   = lvl_t'(level_of(int'(torque_q), N_LED, TMAX));
  assign tgt_l = (instr_q == LEFT  || instr_q == FWD) ? tgt : '0;
  assign tgt_r = (instr_q == RIGHT || instr_q == FWD) ? tgt : '0;

  // Only a direct LEFT<->RIGHT swap with the old side still lit forces a drain.
  assign rev_to_right = (instr_prev == LEFT)  && (instr_q == RIGHT) && (lvl_l != '0);
  assign rev_to_left  = (instr_prev == RIGHT) && (instr_q == LEFT)  && (lvl_r != '0);
  assign enter_drain  = (state == TRACK) && (rev_to_right || rev_to_left);
  assign drain_sel    = (state == DRAIN) ? drain_left : rev_to_right;
  assign drain_lvl    = drain_sel ? lvl_l : lvl_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= STOP;
      instr_prev <= STOP;
      torque_q   <= '0;
      state      <= IDLE;
      lvl_l      <= '0;
      lvl_r      <= '0;
      drain_left <= 1'b0;
      settled    <= 1'b0;
    end else begin
      instr_q    <= instr_e'(instruction);
      instr_prev <= instr_q;
      torque_q   <= torque;
      if (!enable) begin
        state   <= IDLE;
        lvl_l   <= '0;
        lvl_r   <= '0;
        settled <= 1'b0;
      end else begin
        settled <= (state == TRACK) && (lvl_l == tgt_l) && (lvl_r == tgt_r);
        case (state)
          IDLE: state <= TRACK;
          TRACK, DRAIN: begin
            if (state == DRAIN || enter_drain) begin
              drain_left <= drain_sel;
              if (tick && drain_lvl != '0) begin
                if (drain_sel) lvl_l <= lvl_l - lvl_t'(1);
                else           lvl_r <= lvl_r - lvl_t'(1);
              end
              state <= (drain_lvl == '0 || (tick && drain_lvl == lvl_t'(1))) ? TRACK : DRAIN;
            end else if (tick) begin
              lvl_l <= step_to(lvl_l, tgt_l);
              lvl_r <= step_to(lvl_r, tgt_r);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef TORQUE_HAZARD_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt;
  logic          blink_on, haz_act;

  assign haz_act = (state == TRACK) && (instr_q == STOP) && (lvl_l == '0) && (lvl_r == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!haz_act) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BW'(BLINK_DIV - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end
`endif

  always_comb begin
    left_LED  = '0;
    right_LED = '0;
    for (int i = 0; i < N_LED; i++) begin
      left_LED[i]  = (i < int'(lvl_l));
      right_LED[i] = (i >= N_LED - int'(lvl_r));
    end
`ifdef TORQUE_HAZARD_EN
    if (haz_act && blink_on) begin
      left_LED[N_LED-1] = 1'b1;
      right_LED[0]      = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_torque_bar_animator.sv
// Randomized self-checking bench for torque_bar_animator with a tick-level bar model.
module tb_torque_bar_animator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [1:0] instruction;
  logic [1:0] torque;
  logic [8:0] left_LED, right_LED;
  logic       settled;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef TORQUE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  torque_bar_animator #(.N_LED(9), .TORQUE_W(2), .STEP_DIV(4), .BLINK_DIV(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .instruction(instruction),
    .torque     (torque),
    .left_LED   (left_LED),
    .right_LED  (right_LED),
    .settled    (settled)
  );

  always #5 clk = ~clk;

  // Expected bar images: n innermost LEDs lit on each side.
  function automatic logic [8:0] bar_left(input int n);
    logic [9:0] m;
    m = (10'd1 << n) - 10'd1;
    return m[8:0];
  endfunction

  function automatic logic [8:0] bar_right(input int n);
    logic [9:0] m;
    m = (10'd1 << (9 - n)) - 10'd1;
    return ~m[8:0];
  endfunction

  function automatic int toward(input int c, input int t);
    return (c < t) ? c + 1 : (c > t) ? c - 1 : c;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clear the display, then enable with fresh inputs; one tick lands every 4 cycles after this.
  task automatic restart(input logic [1:0] ins, input logic [1:0] t);
    enable = 1'b0;
    cycles(1);
    instruction = ins;
    torque      = t;
    enable      = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      enable      = 1'($urandom);
      instruction = 2'($urandom);
      torque      = 2'($urandom);
      cycles(1);
      n_cmp++; if (left_LED !== 9'd0) begin n_bad++; $display("FAIL reset_left: got %b want 0", left_LED); end
      n_cmp++; if (right_LED !== 9'd0) begin n_bad++; $display("FAIL reset_right: got %b want 0", right_LED); end
      n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL reset_settled: got %b want 0", settled); end
    end
    enable = 1'b0;
    rst_n  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instruction = 2'($urandom);
      torque      = 2'($urandom);
      cycles(2);
      n_cmp++; if ({left_LED, right_LED, settled} !== 19'd0) begin
        n_bad++; $display("FAIL idle_outputs: got %b/%b/%b want all 0", left_LED, right_LED, settled);
      end
    end
  endtask

  task automatic test_ramp();
    restart(2'b11, 2'd3);
    for (int k = 1; k <= 9; k++) begin
      cycles(4);
      n_cmp++; if (left_LED !== bar_left(k)) begin n_bad++; $display("FAIL ramp_left k=%0d: got %b want %b", k, left_LED, bar_left(k)); end
      n_cmp++; if (right_LED !== bar_right(k)) begin n_bad++; $display("FAIL ramp_right k=%0d: got %b want %b", k, right_LED, bar_right(k)); end
      if (k == 4) begin
        n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL ramp_settled_mid: got %b want 0", settled); end
      end
    end
    cycles(1);
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL ramp_settled: got %b want 1", settled); end
  endtask

  task automatic test_random_ramp();
    for (int r = 0; r < 4; r++) begin
      logic [1:0] ins, t;
      int ml, mr, tl, tr;
      ins = 2'($urandom_range(1, 3));
      t   = 2'($urandom_range(1, 3));
      restart(ins, t);
      ml = 0; mr = 0;
      for (int phase = 0; phase < 2; phase++) begin
        tl = (ins == 2'b01 || ins == 2'b11) ? 3 * int'(t) : 0;
        tr = (ins == 2'b10 || ins == 2'b11) ? 3 * int'(t) : 0;
        for (int k = 1; k <= 10; k++) begin
          cycles(4);
          ml = toward(ml, tl);
          mr = toward(mr, tr);
          n_cmp++; if (left_LED !== bar_left(ml)) begin n_bad++; $display("FAIL rand_left r=%0d k=%0d: got %b want %b", r, k, left_LED, bar_left(ml)); end
          n_cmp++; if (right_LED !== bar_right(mr)) begin n_bad++; $display("FAIL rand_right r=%0d k=%0d: got %b want %b", r, k, right_LED, bar_right(mr)); end
        end
        t = 2'($urandom_range(0, 3));
        torque = t;
      end
    end
  endtask

  task automatic test_level_map();
    restart(2'b01, 2'd2);
    for (int k = 1; k <= 7; k++) begin
      cycles(4);
      n_cmp++; if (left_LED !== bar_left(k < 6 ? k : 6)) begin n_bad++; $display("FAIL map_left k=%0d: got %b", k, left_LED); end
      n_cmp++; if (right_LED !== 9'd0) begin n_bad++; $display("FAIL map_right k=%0d: got %b want 0", k, right_LED); end
    end
    n_cmp++; if (left_LED !== 9'b000111111) begin n_bad++; $display("FAIL map_t2: got %b want 000111111", left_LED); end
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL map_settled: got %b want 1", settled); end
    torque = 2'd1;
    for (int k = 1; k <= 4; k++) begin
      cycles(4);
      n_cmp++; if (left_LED !== bar_left(6 - k > 3 ? 6 - k : 3)) begin n_bad++; $display("FAIL map_fall k=%0d: got %b", k, left_LED); end
    end
    n_cmp++; if (left_LED !== 9'b000000111) begin n_bad++; $display("FAIL map_t1: got %b want 000000111", left_LED); end
  endtask

  task automatic test_reversal(input bit from_left, input int t);
    logic [8:0] old_bar, new_bar;
    int n;
    n = 3 * t;
    restart(from_left ? 2'b01 : 2'b10, 2'(t));
    cycles(4 * n);
    old_bar = from_left ? left_LED : right_LED;
    n_cmp++; if (old_bar !== (from_left ? bar_left(n) : bar_right(n))) begin n_bad++; $display("FAIL rev_start: got %b (n=%0d)", old_bar, n); end
    instruction = from_left ? 2'b10 : 2'b01;
    for (int k = 1; k <= n; k++) begin
      cycles(4);
      old_bar = from_left ? left_LED : right_LED;
      new_bar = from_left ? right_LED : left_LED;
      n_cmp++; if (old_bar !== (from_left ? bar_left(n - k) : bar_right(n - k))) begin n_bad++; $display("FAIL rev_drain k=%0d: got %b", k, old_bar); end
      n_cmp++; if (new_bar !== 9'd0) begin n_bad++; $display("FAIL rev_hold k=%0d: got %b want 0", k, new_bar); end
      if (k == 1) begin
        n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL rev_settled_drain: got %b want 0", settled); end
      end
    end
    for (int k = 1; k <= n; k++) begin
      cycles(4);
      old_bar = from_left ? left_LED : right_LED;
      new_bar = from_left ? right_LED : left_LED;
      n_cmp++; if (new_bar !== (from_left ? bar_right(k) : bar_left(k))) begin n_bad++; $display("FAIL rev_rise k=%0d: got %b", k, new_bar); end
      n_cmp++; if (old_bar !== 9'd0) begin n_bad++; $display("FAIL rev_old k=%0d: got %b want 0", k, old_bar); end
    end
    cycles(4);
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL rev_settled: got %b want 1", settled); end
  endtask

  task automatic test_abort();
    restart(2'b11, 2'd3);
    cycles(4 * $urandom_range(1, 7) + $urandom_range(0, 3));
    enable = 1'b0;
    cycles(1);
    n_cmp++; if ({left_LED, right_LED} !== 18'd0) begin n_bad++; $display("FAIL abort_bars: got %b/%b want 0", left_LED, right_LED); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL abort_settled: got %b want 0", settled); end
    restart(2'b11, 2'd3);
    cycles(4);
    n_cmp++; if (left_LED !== bar_left(1) || right_LED !== bar_right(1)) begin n_bad++; $display("FAIL reenable: got %b/%b want one LED each", left_LED, right_LED); end
    cycles(4 * $urandom_range(2, 6));
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({left_LED, right_LED} !== 18'd0) begin n_bad++; $display("FAIL async_rst_bars: got %b/%b want 0", left_LED, right_LED); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL async_rst_settled: got %b want 0", settled); end
    #1 rst_n = 1'b1;
    @(negedge clk);
    cycles(3);
    n_cmp++; if (left_LED !== bar_left(1) || right_LED !== bar_right(1)) begin n_bad++; $display("FAIL post_rst_ramp: got %b/%b", left_LED, right_LED); end
  endtask

  task automatic test_hazard();
    logic lit;
    restart(2'b00, 2'($urandom));
    cycles(2);
    n_cmp++; if (left_LED !== (HAZ ? 9'h100 : 9'h000) || right_LED !== (HAZ ? 9'h001 : 9'h000)) begin
      n_bad++; $display("FAIL hazard_start: got %b/%b", left_LED, right_LED);
    end
    cycles(2);
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) cycles(4);
      lit = HAZ && ((k / 2) % 2 == 0);
      n_cmp++; if (left_LED !== (lit ? 9'h100 : 9'h000)) begin n_bad++; $display("FAIL hazard_left k=%0d: got %b lit=%b", k, left_LED, lit); end
      n_cmp++; if (right_LED !== (lit ? 9'h001 : 9'h000)) begin n_bad++; $display("FAIL hazard_right k=%0d: got %b lit=%b", k, right_LED, lit); end
    end
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL hazard_settled: got %b want 1", settled); end
    instruction = 2'b01;
    torque      = 2'd3;
    cycles(1);
    n_cmp++; if ({left_LED, right_LED} !== 18'd0) begin n_bad++; $display("FAIL hazard_leave: got %b/%b want 0", left_LED, right_LED); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; instruction = 2'b00; torque = 2'd0;
    test_reset();
    test_ramp();
    test_random_ramp();
    test_level_map();
    test_reversal(1'b1, 3);
    test_reversal(1'($urandom), $urandom_range(1, 3));
    test_abort();
    test_hazard();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
